crack_scheduler: RTL and testbench

Splits the 4-character base-36 password keyspace into slices of the most-significant digit and dispatches them to a pool of `password_cracker` engines. It collects per-engine completion and match reports, aborts the pool on the first match, and reports the winning slice. It sits between the host/top-level control and the engine array, and is the only block that drives engine `from`/`to`.

---
 rtl/crack_scheduler.sv | 176 +++++++++++++++++
 tb/tb_crack_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/crack_scheduler.sv
// Keyspace scheduler: hands out top-digit slices to a pool of password_cracker
// engines, tracks which engine holds which slice, and stops the pool on the first match.

module crack_slot (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load,
  input  logic [5:0] load_from,
  input  logic       done_q,
  output logic       assigned,
  output logic [5:0] slice_from
);
  // A load beats a clear so the first dispatch can land on the start cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      assigned   <= 1'b0;
      slice_from <= '0;
    end else if (load) begin
      assigned   <= 1'b1;
      slice_from <= load_from;
    end else if (clr || done_q) begin
      assigned   <= 1'b0;
    end
  end
endmodule

module crack_scheduler #(
  parameter int NUM_ENG   = 4,
  parameter int SLICE     = 4,
  parameter int MAX_DIGIT = 35
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [31:0]        password_to_crack,
  output logic               busy,
  output logic               found,
  output logic               done,
  output logic [5:0]         result_slice,
  output logic [NUM_ENG-1:0] eng_start,
  output logic [5:0]         eng_from,
  output logic [5:0]         eng_to,
  output logic [31:0]        eng_password,
  output logic               eng_abort,
  input  logic [NUM_ENG-1:0] eng_done,
  input  logic [NUM_ENG-1:0] eng_found
);
  localparam logic [6:0] SLICE_M1 = 7'(SLICE - 1);
  localparam logic [6:0] SLICE7   = 7'(SLICE);
  localparam logic [6:0] MAX7     = 7'(MAX_DIGIT);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic               vld;
    logic [NUM_ENG-1:0] oh;
    logic [6:0]         from;
    logic [6:0]         to;
  } disp_t;

  state_t                  state, state_d;
  disp_t                   disp;
  logic [6:0]              next_from;
  logic [6:0]              end_raw;
  logic [NUM_ENG-1:0]      assigned, done_q, hit_vec, hit_oh, free_oh;
  logic [NUM_ENG-1:0][5:0] slice_from;
  logic [5:0]              hit_from;
  logic                    hit, still_busy, can_issue, start_acc, exhaust;

  // Completions only count for engines that actually hold a slice.
  assign done_q     = eng_done & assigned;
  assign hit_vec    = (state == RUN) ? (done_q & eng_found) : '0;
  assign hit_oh     = hit_vec & (~hit_vec + NUM_ENG'(1));
  assign free_oh    = ~assigned & (assigned + NUM_ENG'(1));
  assign hit        = |hit_vec;
  assign still_busy = |(assigned & ~done_q);
  assign can_issue  = (next_from <= MAX7);

  always_comb begin
    hit_from = '0;
    for (int i = 0; i < NUM_ENG; i++)
      if (hit_oh[i]) hit_from = slice_from[i];
  end

  genvar g;
  generate
    for (g = 0; g < NUM_ENG; g++) begin : g_slot
      crack_slot u_slot (
        .clk        (clk),
        .rst        (rst),
        .clr        (hit || start_acc),
        .load       (disp.vld && disp.oh[g]),
        .load_from  (disp.from[5:0]),
        .done_q     (done_q[g]),
        .assigned   (assigned[g]),
        .slice_from (slice_from[g])
      );
    end
  endgenerate

  always_comb begin
    state_d   = state;
    disp      = '0;
    start_acc = 1'b0;
    exhaust   = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_d   = RUN;
        start_acc = 1'b1;
        disp.vld  = 1'b1;
        disp.oh   = NUM_ENG'(1);
        disp.from = '0;
      end
      RUN: begin
        if (hit) begin
          state_d = IDLE;
        end else if (!can_issue && !still_busy) begin
          state_d = IDLE;
          exhaust = 1'b1;
        end else if (can_issue && |free_oh) begin
          disp.vld  = 1'b1;
          disp.oh   = free_oh;
          disp.from = next_from;
        end
      end
      default: state_d = IDLE;
    endcase
    end_raw = disp.from + SLICE_M1;
    disp.to = (end_raw > MAX7) ? MAX7 : end_raw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      next_from    <= '0;
      busy         <= 1'b0;
      found        <= 1'b0;
      done         <= 1'b0;
      result_slice <= '0;
      eng_start    <= '0;
      eng_from     <= '0;
      eng_to       <= '0;
      eng_password <= '0;
      eng_abort    <= 1'b0;
    end else begin
      state     <= state_d;
      eng_start <= '0;
      eng_abort <= 1'b0;
      if (start_acc) begin
        eng_password <= password_to_crack;
        found        <= 1'b0;
        done         <= 1'b0;
        result_slice <= '0;
        busy         <= 1'b1;
      end
      if (disp.vld) begin
        eng_start <= disp.oh;
        eng_from  <= disp.from[5:0];
        eng_to    <= disp.to[5:0];
        next_from <= disp.from + SLICE7;
      end
      if (hit) begin
        found        <= 1'b1;
        done         <= 1'b1;
        result_slice <= hit_from;
        eng_abort    <= 1'b1;
        busy         <= 1'b0;
      end
      if (exhaust) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_crack_scheduler.sv
// Directed bench for crack_scheduler: instance 0 uses SLICE=4, instance 1 uses SLICE=5.

module tb_crack_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] password = 32'h30303A30;  // "00:0"

  logic        start [2];
  logic        busy [2];
  logic        found [2];
  logic        done [2];
  logic [5:0]  result_slice [2];
  logic [3:0]  eng_start [2];
  logic [5:0]  eng_from [2];
  logic [5:0]  eng_to [2];
  logic [31:0] eng_password [2];
  logic        eng_abort [2];
  logic [3:0]  eng_done [2];
  logic [3:0]  eng_found [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  crack_scheduler #(.NUM_ENG(4), .SLICE(4), .MAX_DIGIT(35)) dut (
    .clk(clk), .rst(rst), .start(start[0]), .password_to_crack(password),
    .busy(busy[0]), .found(found[0]), .done(done[0]), .result_slice(result_slice[0]),
    .eng_start(eng_start[0]), .eng_from(eng_from[0]), .eng_to(eng_to[0]),
    .eng_password(eng_password[0]), .eng_abort(eng_abort[0]),
    .eng_done(eng_done[0]), .eng_found(eng_found[0])
  );

  crack_scheduler #(.NUM_ENG(4), .SLICE(5), .MAX_DIGIT(35)) dut5 (
    .clk(clk), .rst(rst), .start(start[1]), .password_to_crack(password),
    .busy(busy[1]), .found(found[1]), .done(done[1]), .result_slice(result_slice[1]),
    .eng_start(eng_start[1]), .eng_from(eng_from[1]), .eng_to(eng_to[1]),
    .eng_password(eng_password[1]), .eng_abort(eng_abort[1]),
    .eng_done(eng_done[1]), .eng_found(eng_found[1])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int d, input string tag);
    chk({tag, " busy"}, 64'(busy[d]), 0);
    chk({tag, " found"}, 64'(found[d]), 0);
    chk({tag, " done"}, 64'(done[d]), 0);
    chk({tag, " result_slice"}, 64'(result_slice[d]), 0);
    chk({tag, " eng_start"}, 64'(eng_start[d]), 0);
    chk({tag, " eng_from"}, 64'(eng_from[d]), 0);
    chk({tag, " eng_to"}, 64'(eng_to[d]), 0);
    chk({tag, " eng_abort"}, 64'(eng_abort[d]), 0);
  endtask

  task automatic chk_disp(input int d, input string tag, input logic [3:0] oh,
                          input logic [5:0] f, input logic [5:0] t);
    chk({tag, " eng_start"}, 64'(eng_start[d]), 64'(oh));
    chk({tag, " eng_from"}, 64'(eng_from[d]), 64'(f));
    chk({tag, " eng_to"}, 64'(eng_to[d]), 64'(t));
  endtask

  // Engines finish 3 cycles after load without a match; optional stray done+found
  // on unassigned engine 3 in cycle 1.
  task automatic run_model(input int d, input bit inject, input int exp_n,
                           input logic [5:0] exp_from, input logic [5:0] exp_to);
    int cnt [4] = '{0, 0, 0, 0};
    int n = 0, cyc = 0, last_done_cyc = -1, done_cyc = -1;
    bit abort_seen = 0, found_seen = 0;
    logic [5:0] lf = '0, lt = '0;
    start[d] = 1'b1;
    step();
    start[d] = 1'b0;
    cyc = 1;
    while (cyc < 400 && done_cyc < 0) begin
      abort_seen |= eng_abort[d];
      found_seen |= found[d];
      if (done[d]) begin
        done_cyc = cyc;
      end else begin
        eng_done[d]  = '0;
        eng_found[d] = '0;
        for (int i = 0; i < 4; i++)
          if (cnt[i] > 0) begin
            cnt[i]--;
            if (cnt[i] == 0) eng_done[d][i] = 1'b1;
          end
        for (int i = 0; i < 4; i++)
          if (eng_start[d][i]) begin
            n++;
            lf = eng_from[d];
            lt = eng_to[d];
            cnt[i] = 3;
          end
        if (eng_done[d] != 0) last_done_cyc = cyc;
        if (inject && cyc == 1) begin
          eng_done[d][3]  = 1'b1;
          eng_found[d][3] = 1'b1;
        end
        step();
        cyc++;
      end
    end
    eng_done[d]  = '0;
    eng_found[d] = '0;
    chk("exh done_latency", 64'(done_cyc), 64'(last_done_cyc + 1));
    chk("exh dispatch_count", 64'(n), 64'(exp_n));
    chk("exh last_from", 64'(lf), 64'(exp_from));
    chk("exh last_to", 64'(lt), 64'(exp_to));
    chk("exh found_seen", 64'(found_seen), 0);
    chk("exh abort_seen", 64'(abort_seen), 0);
    chk("exh busy", 64'(busy[d]), 0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; eng_done[d] = '0; eng_found[d] = '0;
    end
    step();
    chk_idle(0, "reset0");
    chk_idle(1, "reset1");
    rst = 1'b0;
    step();

    // Match on engine 2 after full initial fan-out.
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    chk("m1 busy", 64'(busy[0]), 1);
    chk("m1 password", 64'(eng_password[0]), 64'h30303A30);
    chk_disp(0, "m1 c1", 4'b0001, 0, 3);
    step(); chk_disp(0, "m1 c2", 4'b0010, 4, 7);
    step(); chk_disp(0, "m1 c3", 4'b0100, 8, 11);
    step(); chk_disp(0, "m1 c4", 4'b1000, 12, 15);
    step(); chk("m1 c5 no_start", 64'(eng_start[0]), 0);
    eng_done[0] = 4'b0100; eng_found[0] = 4'b0100;
    step();
    eng_done[0] = '0; eng_found[0] = '0;
    chk("m1 found", 64'(found[0]), 1);
    chk("m1 done", 64'(done[0]), 1);
    chk("m1 result_slice", 64'(result_slice[0]), 8);
    chk("m1 abort", 64'(eng_abort[0]), 1);
    chk("m1 busy_low", 64'(busy[0]), 0);
    chk("m1 no_start", 64'(eng_start[0]), 0);
    step();
    chk("m1 abort_once", 64'(eng_abort[0]), 0);
    chk("m1 no_start2", 64'(eng_start[0]), 0);
    chk("m1 found_held", 64'(found[0]), 1);

    // Engines 1 and 3 match together; the lower index wins.
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    chk("m2 found_cleared", 64'(found[0]), 0);
    chk("m2 done_cleared", 64'(done[0]), 0);
    step(); step(); step(); step();
    eng_done[0] = 4'b1010; eng_found[0] = 4'b1010;
    step();
    eng_done[0] = '0; eng_found[0] = '0;
    chk("m2 found", 64'(found[0]), 1);
    chk("m2 result_slice", 64'(result_slice[0]), 4);
    step();

    // Ignored start while busy, reload two cycles after a done, then reset mid-search.
    start[0] = 1'b1;
    step();                       // cycle 1
    start[0] = 1'b0;
    step();                       // cycle 2
    start[0] = 1'b1;
    step();                       // cycle 3
    start[0] = 1'b0;
    chk_disp(0, "r c3", 4'b0100, 8, 11);
    step();                       // cycle 4
    chk_disp(0, "r c4", 4'b1000, 12, 15);
    eng_done[0] = 4'b0001; eng_found[0] = 4'b0000;
    step();                       // cycle 5
    eng_done[0] = '0;
    chk("r c5 no_start", 64'(eng_start[0]), 0);
    step();                       // cycle 6
    chk_disp(0, "r c6 reload", 4'b0001, 16, 19);
    rst = 1'b1;
    step();                       // cycle 7
    rst = 1'b0;
    chk_idle(0, "midreset");
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    chk_disp(0, "restart", 4'b0001, 0, 3);
    chk("restart busy", 64'(busy[0]), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    run_model(0, 1'b0, 9, 32, 35);
    run_model(1, 1'b1, 8, 35, 35);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
